// File: rtl/rf_write_arbiter_if.sv
// Bus bundle for the GRF write-port arbiter.
// master drives pipe/late/query inputs; slave is the arbiter.
interface rf_write_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd;
  logic [31:0] pipe_pc;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_a3;
  logic [31:0] late_wd;
  logic [31:0] late_pc;
  logic [4:0]  q1_a;
  logic [4:0]  q2_a;
  logic        q1_pend;
  logic        q2_pend;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] rf_wpc;

  modport master (
    output pipe_we, pipe_a3, pipe_wd, pipe_pc,
    output late_valid, late_a3, late_wd, late_pc,
    output q1_a, q2_a,
    input  late_ready, q1_pend, q2_pend,
    input  rf_we, rf_a3, rf_wd, rf_wpc
  );

  modport slave (
    input  pipe_we, pipe_a3, pipe_wd, pipe_pc,
    input  late_valid, late_a3, late_wd, late_pc,
    input  q1_a, q2_a,
    output late_ready, q1_pend, q2_pend,
    output rf_we, rf_a3, rf_wd, rf_wpc
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// GRF write-port arbiter: W-stage writes win, late results queue.
// Optional WB_TRACE_EN macro prints each committed write.
module rf_write_arbiter #(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic reset,
  rf_write_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_vld;
  logic [4:0]       r_ma3 [DEPTH];
  logic [31:0]      r_mwd [DEPTH];
  logic [31:0]      r_mpc [DEPTH];

  logic        r_we;
  logic [4:0]  r_a3;
  logic [31:0] r_wd;
  logic [31:0] r_wpc;

  logic w_pipe;
  logic w_acc;
  logic w_empty;
  logic w_pop;
  logic w_byp;
  logic w_push;
  logic w_ready;
  logic w_q1p;
  logic w_q2p;

  assign w_ready = !reset && (r_count < CW'(DEPTH));
  assign w_pipe  = bus.pipe_we && (bus.pipe_a3 != 5'd0);
  assign w_acc   = bus.late_valid && w_ready;
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_pipe && !w_empty;
  assign w_byp   = !w_pipe && w_empty && w_acc
                && (bus.late_a3 != 5'd0);
  // $0 and same-register-as-pipe late writes are dropped
  assign w_push  = w_acc && (bus.late_a3 != 5'd0) && !w_byp
                && !(w_pipe && bus.late_a3 == bus.pipe_a3);

  // FIFO control: squash, pop, push, occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_pipe && r_ma3[i] == bus.pipe_a3)
          r_vld[i] <= 1'b0;
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + AW'(1);
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + AW'(1);
      end
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ma3[r_tail] <= bus.late_a3;
      r_mwd[r_tail] <= bus.late_wd;
      r_mpc[r_tail] <= bus.late_pc;
    end
  end

  // Port arbitration into the registered GRF write stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_wd  <= '0;
      r_wpc <= '0;
    end else if (w_pipe) begin
      r_we  <= 1'b1;
      r_a3  <= bus.pipe_a3;
      r_wd  <= bus.pipe_wd;
      r_wpc <= bus.pipe_pc;
    end else if (w_pop) begin
      r_we <= r_vld[r_head];
      if (r_vld[r_head]) begin
        r_a3  <= r_ma3[r_head];
        r_wd  <= r_mwd[r_head];
        r_wpc <= r_mpc[r_head];
      end
    end else if (w_byp) begin
      r_we  <= 1'b1;
      r_a3  <= bus.late_a3;
      r_wd  <= bus.late_wd;
      r_wpc <= bus.late_pc;
    end else begin
      r_we <= 1'b0;
    end
  end

  // Pending flags from live FIFO entries only
  always_comb begin
    w_q1p = 1'b0;
    w_q2p = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && bus.q1_a != 5'd0 && r_ma3[i] == bus.q1_a)
        w_q1p = 1'b1;
      if (r_vld[i] && bus.q2_a != 5'd0 && r_ma3[i] == bus.q2_a)
        w_q2p = 1'b1;
    end
  end

  assign bus.late_ready = w_ready;
  assign bus.q1_pend    = w_q1p;
  assign bus.q2_pend    = w_q2p;
  assign bus.rf_we      = r_we;
  assign bus.rf_a3      = r_a3;
  assign bus.rf_wd      = r_wd;
  assign bus.rf_wpc     = r_wpc;

`ifdef WB_TRACE_EN
  // Commit trace at the edge the GRF writes
  always @(posedge clk) begin
    if (r_we)
      $display("%d@%h: $%d <= %h", $time, r_wpc, r_a3, r_wd);
  end
`else
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed + random bench for rf_write_arbiter.
// Reference model keeps the late queue as a SV queue.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    bit          ok;
  } ent_t;

  ent_t mq[$];
  logic        e_we;
  logic [4:0]  e_a3;
  logic [31:0] e_wd;
  logic [31:0] e_pc;
  bit          m_acc;
  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit mpend(logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i])
      if (mq[i].ok && mq[i].a3 == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check comb outputs, advance model, check rf_*
  task automatic step();
    bit rdy, pipe, byp;
    ent_t e;
    #1;
    rdy = !rst && (mq.size() < DEPTH);
    chk("late_ready", 32'(bus.late_ready), 32'(rdy));
    chk("q1_pend", 32'(bus.q1_pend), 32'(mpend(bus.q1_a)));
    chk("q2_pend", 32'(bus.q2_pend), 32'(mpend(bus.q2_a)));
    m_acc = bus.late_valid && rdy;
    pipe  = bus.pipe_we && bus.pipe_a3 != 5'd0;
    byp   = 1'b0;
    if (rst) begin
      mq.delete();
      e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
    end else begin
      if (pipe) begin
        foreach (mq[i])
          if (mq[i].a3 == bus.pipe_a3) mq[i].ok = 1'b0;
        e_we = 1; e_a3 = bus.pipe_a3;
        e_wd = bus.pipe_wd; e_pc = bus.pipe_pc;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        e_we = e.ok;
        if (e.ok) begin
          e_a3 = e.a3; e_wd = e.wd; e_pc = e.pc;
        end
      end else if (m_acc && bus.late_a3 != 5'd0) begin
        byp = 1'b1;
        e_we = 1; e_a3 = bus.late_a3;
        e_wd = bus.late_wd; e_pc = bus.late_pc;
      end else begin
        e_we = 0;
      end
      if (m_acc && bus.late_a3 != 5'd0 && !byp &&
          !(pipe && bus.late_a3 == bus.pipe_a3)) begin
        e.a3 = bus.late_a3; e.wd = bus.late_wd;
        e.pc = bus.late_pc; e.ok = 1'b1;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("rf_we", 32'(bus.rf_we), 32'(e_we));
    chk("rf_a3", 32'(bus.rf_a3), 32'(e_a3));
    chk("rf_wd", bus.rf_wd, e_wd);
    chk("rf_wpc", bus.rf_wpc, e_pc);
    @(negedge clk);
  endtask

  task automatic pipe(bit we, logic [4:0] a, logic [31:0] d,
                      logic [31:0] p);
    bus.pipe_we = we; bus.pipe_a3 = a;
    bus.pipe_wd = d;  bus.pipe_pc = p;
  endtask

  task automatic late(bit v, logic [4:0] a, logic [31:0] d,
                      logic [31:0] p);
    bus.late_valid = v; bus.late_a3 = a;
    bus.late_wd = d;    bus.late_pc = p;
  endtask

  initial begin
    rst = 1'b1;
    pipe(1, 5'd7, 32'h1, 32'h0);
    late(0, 0, 0, 0);
    bus.q1_a = 0; bus.q2_a = 0;
    @(negedge clk);

    // reset held 2 cycles with pipe_we=1
    step();
    chk("rst_ready", 32'(bus.late_ready), 32'd0);
    step();
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    rst = 1'b0;
    pipe(0, 0, 0, 0);
    #1 chk("post_rst_ready", 32'(bus.late_ready), 32'd1);
    chk("post_rst_we", 32'(bus.rf_we), 32'd0);
    @(negedge clk);

    // pipe only, then $0
    pipe(1, 5'd5, 32'h1234, 32'h3000);
    step();
    chk("pipe_a3", 32'(bus.rf_a3), 32'd5);
    chk("pipe_wd", bus.rf_wd, 32'h1234);
    pipe(1, 5'd0, 32'h9999, 32'h3004);
    step();
    chk("pipe_zero_we", 32'(bus.rf_we), 32'd0);

    // pipe priority, late entries queue
    pipe(1, 5'd8, 32'h8, 32'h3010);
    late(1, 5'd9, 32'hAA, 32'h4000);
    step();
    late(1, 5'd10, 32'hBB, 32'h4004);
    step();
    late(0, 0, 0, 0);
    bus.q1_a = 5'd9;
    #1 chk("full_ready", 32'(bus.late_ready), 32'd0);
    chk("q1_pend9", 32'(bus.q1_pend), 32'd1);
    step();
    pipe(0, 0, 0, 0);
    step();
    chk("drain1_wd", bus.rf_wd, 32'hAA);
    step();
    chk("drain2_a3", 32'(bus.rf_a3), 32'd10);
    chk("drain2_wd", bus.rf_wd, 32'hBB);
    step();
    chk("drain_ready", 32'(bus.late_ready), 32'd1);

    // bypass on empty FIFO
    bus.q1_a = 5'd3; bus.q2_a = 5'd3;
    late(1, 5'd3, 32'h77, 32'h5000);
    step();
    chk("byp_wd", bus.rf_wd, 32'h77);
    late(0, 0, 0, 0);
    step();

    // WAW squash
    pipe(1, 5'd2, 32'h2, 32'h6000);
    late(1, 5'd4, 32'h11, 32'h6100);
    bus.q1_a = 5'd4;
    step();
    late(0, 0, 0, 0);
    pipe(1, 5'd4, 32'h22, 32'h6004);
    #1 chk("waw_pend", 32'(bus.q1_pend), 32'd1);
    step();
    chk("waw_wd", bus.rf_wd, 32'h22);
    pipe(0, 0, 0, 0);
    #1 chk("waw_pend_clr", 32'(bus.q1_pend), 32'd0);
    step();
    chk("waw_slot_we", 32'(bus.rf_we), 32'd0);
    step();

    // pointer wrap: one entry, then accept+pop each cycle
    pipe(1, 5'd1, 32'h1, 32'h7000);
    late(1, 5'd20, 32'h100, 32'h7100);
    step();
    pipe(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      late(1, 5'(21 + i), 32'h101 + i, 32'h7104 + 4 * i);
      step();
    end
    late(0, 0, 0, 0);
    step();

    // reset with 2 entries queued
    pipe(1, 5'd6, 32'h6, 32'h8000);
    late(1, 5'd12, 32'hC, 32'h8100);
    step();
    late(1, 5'd13, 32'hD, 32'h8104);
    step();
    late(0, 0, 0, 0);
    pipe(0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_drain_we", 32'(bus.rf_we), 32'd0);
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(49, 0) == 0);
      pipe($urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)),
           $urandom, $urandom);
      if (!(bus.late_valid && !m_acc))
        late($urandom_range(9, 0) < 6, 5'($urandom_range(7, 0)),
             $urandom, $urandom);
      bus.q1_a = 5'($urandom_range(7, 0));
      bus.q2_a = 5'($urandom_range(7, 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
